fir_mc_filter: RTL and testbench

//  Time-multiplexed, multi-channel, signed FIR filter. Coefficients are loadable at run time.

---
 rtl/fir_mc_filter.sv | 205 ++++++++++++++++++++
 tb/tb_fir_mc_filter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_filter.sv
// -----------------------------------------------------------------------------
// fir_mc_filter
//   Time-multiplexed, multi-channel, signed FIR filter with run-time loadable
//   coefficients. One shared multiply-accumulate computes one tap per clock.
//   Each channel has its own circular delay line and write pointer, and all
//   channels share one coefficient set. The result is rounded and saturated.
//
// Ports
//   clock, nreset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      sample handshake (in_ready is high only in IDLE)
//   in_chan, xn            channel and signed sample being offered
//   out_valid/out_ready    result handshake; the result is held until accepted
//   out_chan, yn, sat      channel, signed result, result-was-clipped flag
//   coef_we/addr/data      coefficient write port (applied only in IDLE)
//   coef_err               1-cycle pulse: coefficient write ignored
//   chan_err               1-cycle pulse: sample dropped (bad channel)
// -----------------------------------------------------------------------------
module fir_mc_filter #(
  parameter int WIDTH  = 32,
  parameter int COEF_W = 16,
  parameter int NCOEFS = 29,
  parameter int NCHAN  = 2,
  parameter int FRAC   = 15,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW    = (NCOEFS > 1) ? $clog2(NCOEFS) : 1
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_chan,
  input  logic signed [WIDTH-1:0]  xn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_chan,
  output logic signed [WIDTH-1:0]  yn,
  output logic                     sat,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic                     chan_err
);

  // The reset coefficient is exactly 1.0 (1 << FRAC), which does not fit a
  // signed COEF_W word when FRAC >= COEF_W-1. Coefficients are therefore held
  // one bit wider where needed; written values are sign-extended into it.
  localparam int HW    = (FRAC + 2 > COEF_W) ? FRAC + 2 : COEF_W;
  localparam int PW    = WIDTH + HW;
  localparam int ACC_W = WIDTH + HW + $clog2(NCOEFS);
  localparam int RW    = ACC_W + 1;               // headroom for the rounding add
  localparam int KW    = $clog2(NCOEFS + 1);      // k counts 0..NCOEFS
  localparam int HSH   = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [HW-1:0] H_ONE = HW'(1) <<< FRAC;
  localparam logic signed [RW-1:0] HALF  = (FRAC > 0) ? (RW'(1) <<< HSH) : '0;
  localparam logic signed [RW-1:0] YMAX  = (RW'(1) <<< (WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] YMIN  = -(RW'(1) <<< (WIDTH - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [HW-1:0]    h          [NCOEFS];
  logic signed [WIDTH-1:0] delay_line [NCHAN][NCOEFS];
  logic [AW-1:0]           wptr       [NCHAN];

  logic [CW-1:0]           cur_chan;
  logic [KW-1:0]           k;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;

  logic                    chan_ok;
  logic                    addr_ok;
  logic                    accept;
  logic                    tap_live;
  logic [AW-1:0]           rd_tap;
  logic [AW-1:0]           rd_idx;
  int                      rd_diff;
  logic signed [PW-1:0]    prod_c;
  logic signed [RW-1:0]    rnd_sum;
  logic signed [RW-1:0]    rnd_q;
  logic signed [WIDTH-1:0] y_c;
  logic                    sat_c;

  assign chan_ok  = ({1'b0, in_chan} < (CW + 1)'(NCHAN));
  assign addr_ok  = ({1'b0, coef_addr} < (AW + 1)'(NCOEFS));
  assign accept   = (state == IDLE) && in_valid && chan_ok;
  assign tap_live = (k < KW'(NCOEFS));

  // Tap k reads x[n-k] = delay_line[ch][(wptr - k) mod NCOEFS]. The product
  // is registered, so MAC runs one cycle longer than the tap count: the extra
  // cycle folds the last product into acc.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_tap  = '0;
    rd_idx  = '0;
    rd_diff = 0;
    if (tap_live) begin
      rd_tap  = AW'(k);
      rd_diff = int'(wptr[cur_chan]) + NCOEFS - int'(k);
      if (rd_diff >= NCOEFS) rd_diff = rd_diff - NCOEFS;
      rd_idx  = AW'(rd_diff);
    end
  end

  assign prod_c = PW'(h[rd_tap]) * PW'(delay_line[cur_chan][rd_idx]);

  // Round half up at the binary point, then clip to the output range.
  always_comb begin
    rnd_sum = RW'(acc) + HALF;
    rnd_q   = rnd_sum >>> FRAC;
    y_c     = rnd_q[WIDTH-1:0];
    sat_c   = 1'b0;
    if (rnd_q > YMAX) begin
      y_c   = YMAX[WIDTH-1:0];
      sat_c = 1'b1;
    end else if (rnd_q < YMIN) begin
      y_c   = YMIN[WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_chan  = out_valid ? cur_chan : '0;
  assign yn        = out_valid ? y_c : '0;
  assign sat       = out_valid & sat_c;

  always_ff @(posedge clock or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (!tap_live) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      // NOTE: coefficient and delay-line storage is reset deliberately: the
      // identity filter and the all-zero history are part of the reset state,
      // so these arrays are flops rather than an uninitialised RAM.
      for (int i = 0; i < NCOEFS; i++) h[i] <= (i == 0) ? H_ONE : '0;
      for (int c = 0; c < NCHAN; c++) begin
        wptr[c] <= '0;
        for (int i = 0; i < NCOEFS; i++) delay_line[c][i] <= '0;
      end
      cur_chan <= '0;
      k        <= '0;
      prod     <= '0;
      acc      <= '0;
      coef_err <= 1'b0;
      chan_err <= 1'b0;
    end else begin
      coef_err <= 1'b0;
      chan_err <= 1'b0;

      // A write on the accepting edge lands before the first MAC cycle, so
      // the sample being accepted already sees the new coefficient.
      if (coef_we) begin
        if (state == IDLE && addr_ok) h[coef_addr] <= HW'(coef_data);
        else                          coef_err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (chan_ok) begin
              delay_line[in_chan][wptr[in_chan]] <= xn;
              cur_chan <= in_chan;
              k        <= '0;
              acc      <= '0;
              prod     <= '0;
            end else begin
              chan_err <= 1'b1;
            end
          end
        end
        MAC: begin
          acc  <= acc + ACC_W'(prod);
          prod <= tap_live ? prod_c : '0;
          k    <= k + KW'(1);
        end
        OUT: begin
          if (out_ready) begin
            wptr[cur_chan] <= (wptr[cur_chan] == AW'(NCOEFS - 1)) ? '0
                                                                  : wptr[cur_chan] + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_mc_filter
//   Self-checking bench for fir_mc_filter. A behavioural model keeps, per
//   channel, the most recent NCOEFS samples newest-first and evaluates the
//   filter sum directly with 64-bit arithmetic, then rounds and clips.
//   The DUT is built with three channels so the 2-bit in_chan has an
//   out-of-range code for the dropped-sample path.
// -----------------------------------------------------------------------------
module tb_fir_mc_filter;

  localparam int WIDTH  = 32;
  localparam int COEF_W = 16;
  localparam int NCOEFS = 29;
  localparam int NCHAN  = 3;
  localparam int FRAC   = 15;
  localparam int CW     = 2;
  localparam int AW     = 5;
  localparam int LAT    = NCOEFS + 1;
  localparam longint YMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint YMIN = -(longint'(1) <<< (WIDTH - 1));

  logic                     clock = 1'b0;
  logic                     nreset;
  logic                     in_valid;
  logic                     in_ready;
  logic [CW-1:0]            in_chan;
  logic signed [WIDTH-1:0]  xn;
  logic                     out_valid;
  logic                     out_ready;
  logic [CW-1:0]            out_chan;
  logic signed [WIDTH-1:0]  yn;
  logic                     sat;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_err;
  logic                     chan_err;

  int checks = 0;
  int errors = 0;

  longint hm   [NCOEFS];
  longint hist [NCHAN][NCOEFS];

  fir_mc_filter #(
    .WIDTH(WIDTH), .COEF_W(COEF_W), .NCOEFS(NCOEFS), .NCHAN(NCHAN), .FRAC(FRAC)
  ) dut (
    .clock(clock), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .xn(xn),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .yn(yn), .sat(sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .chan_err(chan_err)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NCOEFS; i++) hm[i] = (i == 0) ? (longint'(1) <<< FRAC) : 0;
    for (int c = 0; c < NCHAN; c++)
      for (int i = 0; i < NCOEFS; i++) hist[c][i] = 0;
  endtask

  task automatic model_write(input int addr, input logic signed [COEF_W-1:0] d);
    if (addr < NCOEFS) hm[addr] = longint'(d);
  endtask

  task automatic model_sample(input int ch, input logic signed [WIDTH-1:0] x,
                              output logic signed [WIDTH-1:0] y, output logic s);
    longint acc;
    longint r;
    for (int i = NCOEFS - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = longint'(x);
    acc = 0;
    for (int i = 0; i < NCOEFS; i++) acc += hm[i] * hist[ch][i];
    r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    s = 1'b0;
    if (r > YMAX) begin r = YMAX; s = 1'b1; end
    else if (r < YMIN) begin r = YMIN; s = 1'b1; end
    y = r[WIDTH-1:0];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    nreset = 1'b0; in_valid = 1'b0; in_chan = '0; xn = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    nreset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] d);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = d;
    tick();
    coef_we = 1'b0;
    model_write(addr, d);
  endtask

  task automatic set_avg4();
    for (int a = 0; a < NCOEFS; a++) write_coef(a, (a < 4) ? 16'sh2000 : 16'sh0000);
  endtask

  // Offers one sample, then waits (bounded) for out_valid. Returns the number
  // of edges after the accepting edge at which out_valid was first seen.
  task automatic send(input int ch, input logic signed [WIDTH-1:0] x, output int lat);
    in_valid = 1'b1; in_chan = CW'(ch); xn = x;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * LAT) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat;
    logic signed [WIDTH-1:0] ey;
    logic es;
    apply_reset();
    checks++;
    if ({out_valid, in_ready, sat, coef_err, chan_err} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 01000", {out_valid, in_ready, sat, coef_err, chan_err});
    end
    checks++;
    if (yn !== '0 || out_chan !== '0) begin
      errors++;
      $display("FAIL reset_data: got yn=%h chan=%0d want 0/0", yn, out_chan);
    end
    send(0, 32'sh00001000, lat);
    model_sample(0, 32'sh00001000, ey, es);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (yn !== 32'sh00001000 || yn !== ey) begin
      errors++; $display("FAIL identity_yn: got %h want %h", yn, ey);
    end
    checks++;
    if (out_chan !== 2'd0 || sat !== es) begin
      errors++; $display("FAIL identity_flags: got chan=%0d sat=%b want 0/%b", out_chan, sat, es);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handshake_done: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_moving_avg();
    int lat;
    logic signed [WIDTH-1:0] ey;
    logic es;
    apply_reset();
    set_avg4();
    for (int i = 0; i < 4; i++) begin
      send(0, 32'sh00004000, lat);
      model_sample(0, 32'sh00004000, ey, es);
      checks++;
      if (yn !== WIDTH'((i + 1) * 32'h1000) || yn !== ey || sat !== 1'b0 || lat !== LAT) begin
        errors++;
        $display("FAIL avg4_step%0d: got yn=%h sat=%b lat=%0d want %h/0/%0d", i, yn, sat, lat, ey, LAT);
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    int lat;
    logic signed [WIDTH-1:0] ey;
    logic es;
    apply_reset();
    set_avg4();
    for (int i = 0; i < 4; i++) begin
      send(0, 32'sh00004000, lat);
      model_sample(0, 32'sh00004000, ey, es);
      checks++;
      if (yn !== WIDTH'((i + 1) * 32'h1000) || yn !== ey || out_chan !== 2'd0) begin
        errors++; $display("FAIL ilv_ch0_%0d: got yn=%h chan=%0d want %h/0", i, yn, out_chan, ey);
      end
      tick();
      send(1, 32'sh00000000, lat);
      model_sample(1, 32'sh00000000, ey, es);
      checks++;
      if (yn !== '0 || yn !== ey || out_chan !== 2'd1) begin
        errors++; $display("FAIL ilv_ch1_%0d: got yn=%h chan=%0d want 0/1", i, yn, out_chan);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic signed [WIDTH-1:0] ey;
    logic es;
    logic signed [WIDTH-1:0] pat [4];
    pat[0] = 32'sh7FFFFFFF; pat[1] = 32'sh7FFFFFFF;
    pat[2] = 32'sh80000000; pat[3] = 32'sh80000000;
    apply_reset();
    write_coef(0, 16'sh7FFF);
    write_coef(1, 16'sh7FFF);
    for (int i = 0; i < 4; i++) begin
      send(0, pat[i], lat);
      model_sample(0, pat[i], ey, es);
      checks++;
      if (yn !== ey || sat !== es) begin
        errors++; $display("FAIL sat_model%0d: got yn=%h sat=%b want %h/%b", i, yn, sat, ey, es);
      end
      if (i == 1 || i == 3) begin
        checks++;
        if (yn !== pat[i] || sat !== 1'b1) begin
          errors++; $display("FAIL sat_clip%0d: got yn=%h sat=%b want %h/1", i, yn, sat, pat[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic signed [WIDTH-1:0] ey;
    logic es;
    apply_reset();
    set_avg4();
    out_ready = 1'b0;
    send(1, 32'sh00004000, lat);
    model_sample(1, 32'sh00004000, ey, es);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_chan = 2'd1; xn = $urandom;
      tick();
      checks++;
      if (out_valid !== 1'b1 || yn !== ey || in_ready !== 1'b0 || out_chan !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b yn=%h ready=%b want 1/%h/0", i, out_valid, yn, in_ready, ey);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_once: got %0d extra valid cycles want 0", bad); end
    send(1, 32'sh00004000, lat);
    model_sample(1, 32'sh00004000, ey, es);
    checks++;
    if (yn !== 32'sh00002000 || yn !== ey) begin
      errors++; $display("FAIL bp_no_accept: got %h want %h", yn, ey);
    end
    tick();
  endtask

  task automatic test_errors();
    int lat;
    int bad;
    logic signed [WIDTH-1:0] ey;
    logic es;
    apply_reset();
    // coefficient write while busy
    in_valid = 1'b1; in_chan = 2'd0; xn = 32'sh12345678;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'sh1000;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin errors++; $display("FAIL coef_busy_err: got %b want 1", coef_err); end
    tick();
    checks++;
    if (coef_err !== 1'b0) begin errors++; $display("FAIL coef_err_pulse: got %b want 0", coef_err); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * LAT) begin tick(); lat++; end
    model_sample(0, 32'sh12345678, ey, es);
    checks++;
    if (out_valid !== 1'b1 || yn !== ey) begin
      errors++; $display("FAIL coef_busy_yn: got valid=%b yn=%h want 1/%h", out_valid, yn, ey);
    end
    tick();
    send(0, 32'sh00ABCDEF, lat);
    model_sample(0, 32'sh00ABCDEF, ey, es);
    checks++;
    if (yn !== ey) begin errors++; $display("FAIL coef_unchanged: got %h want %h", yn, ey); end
    tick();
    // out-of-range and in-range coefficient addresses in IDLE
    coef_we = 1'b1; coef_addr = 5'd29; coef_data = 16'sh4000;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin errors++; $display("FAIL coef_addr_err: got %b want 1", coef_err); end
    write_coef(28, 16'sh0100);
    checks++;
    if (coef_err !== 1'b0) begin errors++; $display("FAIL coef_ok_noerr: got %b want 0", coef_err); end
    // bad channel
    in_valid = 1'b1; in_chan = 2'd3; xn = 32'sh7777;
    tick();
    in_valid = 1'b0;
    checks++;
    if (chan_err !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL chan_err: got err=%b ready=%b want 1/1", chan_err, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (out_valid !== 1'b0 || chan_err !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL chan_drop: got %0d bad cycles want 0", bad); end
    // reset in the middle of MAC
    write_coef(0, 16'sh4000);
    in_valid = 1'b1; in_chan = 2'd2; xn = 32'sh01000000;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sat, coef_err, chan_err} !== 5'b01000 || yn !== '0 || out_chan !== '0) begin
      errors++;
      $display("FAIL midreset_out: got flags=%b yn=%h want 01000/0",
               {out_valid, in_ready, sat, coef_err, chan_err}, yn);
    end
    tick();
    nreset = 1'b1;
    model_reset();
    bad = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_abort: got %0d valid cycles want 0", bad); end
    send(2, 32'sh01000000, lat);
    model_sample(2, 32'sh01000000, ey, es);
    checks++;
    if (yn !== 32'sh01000000 || yn !== ey || lat !== LAT) begin
      errors++; $display("FAIL midreset_identity: got yn=%h lat=%0d want %h/%0d", yn, lat, ey, LAT);
    end
    tick();
  endtask

  task automatic test_random();
    int lat;
    int ch;
    int stall;
    int a;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] ey;
    logic signed [COEF_W-1:0] d;
    logic es;
    apply_reset();
    for (int i = 0; i < NCOEFS; i++) begin
      d = COEF_W'($urandom);
      d = d >>> $urandom_range(0, 8);
      write_coef(i, d);
    end
    for (int n = 0; n < 40; n++) begin
      ch = $urandom_range(0, NCHAN - 1);
      x = $urandom;
      if ($urandom_range(0, 1) == 0) x = x >>> $urandom_range(4, 16);
      stall = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        // write on the accepting edge: must affect this sample
        a = $urandom_range(0, NCOEFS - 1);
        d = COEF_W'($urandom);
        coef_we = 1'b1; coef_addr = AW'(a); coef_data = d;
        model_write(a, d);
      end
      out_ready = (stall == 0);
      send(ch, x, lat);
      model_sample(ch, x, ey, es);
      checks++;
      if (lat !== LAT || yn !== ey || sat !== es || out_chan !== CW'(ch)) begin
        errors++;
        $display("FAIL rand%0d: got yn=%h sat=%b chan=%0d lat=%0d want %h/%b/%0d/%0d",
                 n, yn, sat, out_chan, lat, ey, es, ch, LAT);
      end
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_moving_avg();
    test_interleave();
    test_saturation();
    test_backpressure();
    test_errors();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
